// File: rtl/modmul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | modmul_pkg : shared defaults and FSM encoding for the modmul host     |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package modmul_pkg;

    localparam int W_DEF          = 256;
    localparam int TAG_W_DEF      = 4;
    localparam int CLR_CYCLES_DEF = 2;

    localparam int         ST_W     = 3;
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;

endpackage
`default_nettype wire

// File: rtl/modmul_op_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | modmul_op_fifo : operand FIFO, pointer+count, registered full/empty   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module modmul_op_fifo
    import modmul_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    c_CNT_ONE = 1;
    localparam logic [AW:0]    c_CNT_MAX = DEPTH;
    localparam logic [AW-1:0]  c_PTR_ONE = 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          r_full;
    logic          r_empty;
    logic          w_wr;
    logic          w_rd;

    // Flags are registered, so a pop while full frees a slot only next cycle.
    assign w_wr = i_push & ~r_full;
    assign w_rd = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_rd && !w_wr) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNT_MAX);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/modmul_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | modmul_host : job-issuing initiator for the modular multiplier        |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module modmul_host
    import modmul_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [W-1:0]     i_in_x,
    input  logic [W-1:0]     i_in_y,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_mm_start,
    output logic             o_mm_rst,
    output logic [W-1:0]     o_mm_x,
    output logic [W-1:0]     o_mm_y,
    input  logic [W-1:0]     i_mm_q,
    input  logic             i_mm_done,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [W-1:0]     o_out_q,
    output logic [TAG_W-1:0] o_out_tag,
    output logic             o_out_err,
    output logic             o_busy,
    output logic [15:0]      o_job_count
);

    localparam int DW    = 2 * W + TAG_W;
    localparam int CLR_W = $clog2(CLR_CYCLES) + 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam logic [CLR_W-1:0] c_CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CLR_W-1:0] c_CLR_ONE  = 1;
    localparam logic [WD_W-1:0]  c_WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  c_WD_ONE   = 1;

    logic [ST_W-1:0]  r_state;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [WD_W-1:0]  r_wd;
    logic [W-1:0]     r_mm_x;
    logic [W-1:0]     r_mm_y;
    logic [TAG_W-1:0] r_tag;
    logic             r_out_valid;
    logic [W-1:0]     r_out_q;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;
    logic [15:0]      r_job_count;

    logic [DW-1:0]    w_fifo_rd;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_issue;
    logic             w_done_hit;
    logic             w_timeout_hit;
    logic             w_job_end;

    // Issue is held off while a result is unaccepted or done is still sticky.
    assign w_push        = i_in_valid & ~w_fifo_full;
    assign w_issue       = (r_state == ST_IDLE) & ~w_fifo_empty & ~r_out_valid & ~i_mm_done;
    assign w_done_hit    = (r_state == ST_WAIT) & i_mm_done;
    assign w_timeout_hit = (r_state == ST_WAIT) & ~i_mm_done & (r_wd == c_WD_LAST);
    assign w_job_end     = w_done_hit | w_timeout_hit;

    modmul_op_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({i_in_x, i_in_y, i_in_tag}),
        .i_pop   (w_issue),
        .o_data  (w_fifo_rd),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            r_wd      <= '0;
            r_mm_x    <= '0;
            r_mm_y    <= '0;
            r_tag     <= '0;
        end else begin
            case (r_state)
                ST_INIT, ST_CLEAR: begin
                    if (r_clr_cnt == c_CLR_LAST) begin
                        r_clr_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + c_CLR_ONE;
                    end
                end
                ST_IDLE: begin
                    if (w_issue) begin
                        r_mm_x  <= w_fifo_rd[DW-1 -: W];
                        r_mm_y  <= w_fifo_rd[TAG_W +: W];
                        r_tag   <= w_fifo_rd[TAG_W-1:0];
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_job_end) begin
                        r_state <= ST_CLEAR;
                    end else begin
                        r_wd <= r_wd + c_WD_ONE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_q     <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_job_end) begin
            r_out_valid <= 1'b1;
            r_out_q     <= w_done_hit ? i_mm_q : '0;
            r_out_tag   <= r_tag;
            r_out_err   <= ~w_done_hit;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_job_count <= '0;
        end else begin
            r_job_count <= r_job_count + {15'd0, w_job_end};
        end
    end

    assign o_in_ready  = ~w_fifo_full;
    assign o_mm_start  = (r_state == ST_START);
    assign o_mm_rst    = (r_state == ST_INIT) | (r_state == ST_CLEAR);
    assign o_mm_x      = r_mm_x;
    assign o_mm_y      = r_mm_y;
    assign o_out_valid = r_out_valid;
    assign o_out_q     = r_out_q;
    assign o_out_tag   = r_out_tag;
    assign o_out_err   = r_out_err;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_job_count = r_job_count;

endmodule
`default_nettype wire

// File: tb/tb_modmul_host.sv
`default_nettype none
// tb_modmul_host: directed and randomized checks of modmul_host against a
// behavioural multiplier stub and a queue-based result model.
module tb_modmul_host;

    localparam int W          = 256;
    localparam int TAG_W      = 4;
    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 16;
    localparam int CLR_CYCLES = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic [TAG_W-1:0] in_tag;
    logic             mm_start;
    logic             mm_rst;
    logic [W-1:0]     mm_x;
    logic [W-1:0]     mm_y;
    logic [W-1:0]     mm_q;
    logic             mm_done;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_q;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             busy;
    logic [15:0]      job_count;

    int errors  = 0;
    int checks  = 0;
    int n_start = 0;
    int stub_lat = 0;

    typedef struct packed {
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        logic [TAG_W-1:0] tag;
    } job_t;

    job_t        sb[$];
    logic [15:0] exp_jc;

    modmul_host #(
        .W(W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_x(in_x), .i_in_y(in_y), .i_in_tag(in_tag),
        .o_mm_start(mm_start), .o_mm_rst(mm_rst), .o_mm_x(mm_x), .o_mm_y(mm_y),
        .i_mm_q(mm_q), .i_mm_done(mm_done),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_q(out_q), .o_out_tag(out_tag), .o_out_err(out_err),
        .o_busy(busy), .o_job_count(job_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier's arithmetic: product modulo 2^255-19.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [2*W-1:0] m;
        m = (512'd1 << 255) - 512'd19;
        p = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % m;
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Stub multiplier: done rises stub_lat cycles after the start cycle and
    // stays high until mm_rst; stub_lat==0 means it never finishes.
    logic [W-1:0] stub_qr;
    int           stub_cnt;
    logic         stub_armed;
    logic         stub_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_done  <= 1'b0;
            stub_armed <= 1'b0;
            stub_cnt   <= 0;
            stub_qr    <= '0;
        end else if (mm_rst) begin
            stub_done  <= 1'b0;
            stub_armed <= 1'b0;
        end else if (mm_start) begin
            stub_armed <= 1'b1;
            stub_cnt   <= 1;
            stub_qr    <= ref_mul(mm_x, mm_y);
        end else if (stub_armed && !stub_done) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_lat != 0 && stub_cnt + 1 == stub_lat) stub_done <= 1'b1;
        end
    end

    assign mm_done = stub_done;
    assign mm_q    = stub_done ? stub_qr : {8{32'hDEADBEEF}};

    always @(posedge clk) if (mm_start) n_start++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || out_valid) && t < 200) begin
            step();
            t++;
        end
        chk("wait_idle", 256'(busy | out_valid), 256'(0));
    endtask

    // One job from an idle host, checked against timing rules and the model.
    task automatic do_job(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [TAG_W-1:0] tag, input int lat);
        int         t;
        int         rst_len;
        logic       stable;
        logic       overlap;
        logic       exp_err;
        logic [W-1:0] exp_q;
        int         exp_dly;
        exp_err = (lat == 0) || (lat > TIMEOUT);
        exp_q   = exp_err ? '0 : ref_mul(x, y);
        exp_dly = exp_err ? TIMEOUT + 1 : lat + 1;
        stub_lat = lat;
        in_x = x; in_y = y; in_tag = tag; in_valid = 1'b1;
        chk("push_ready", 256'(in_ready), 256'(1));
        step();
        in_valid = 1'b0;
        t = 1;
        while (!mm_start && t < 10) begin
            step();
            t++;
        end
        chk("start_latency", 256'(t), 256'(2));
        chk("mm_x_loaded", mm_x, x);
        chk("mm_y_loaded", mm_y, y);
        t = 0; stable = 1'b1; overlap = 1'b0;
        while (!out_valid && t < TIMEOUT + lat + 8) begin
            step();
            t++;
            if (mm_x !== x || mm_y !== y) stable = 1'b0;
            if (mm_start && mm_rst) overlap = 1'b1;
        end
        chk("done_latency", 256'(t), 256'(exp_dly));
        chk("out_q", out_q, exp_q);
        chk("out_tag", 256'(out_tag), 256'(tag));
        chk("out_err", 256'(out_err), 256'(exp_err));
        exp_jc = exp_jc + 16'd1;
        chk("job_count", 256'(job_count), 256'(exp_jc));
        rst_len = 0;
        while (mm_rst && rst_len < 10) begin
            if (mm_x !== x || mm_y !== y) stable = 1'b0;
            if (mm_start) overlap = 1'b1;
            step();
            rst_len++;
        end
        chk("mm_rst_len", 256'(rst_len), 256'(CLR_CYCLES));
        chk("operands_stable", 256'(stable), 256'(1));
        chk("start_rst_overlap", 256'(overlap), 256'(0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_cleared", 256'(out_valid), 256'(0));
        wait_idle();
    endtask

    initial begin
        logic [W-1:0]     xs [6];
        logic [W-1:0]     ys [6];
        int               pushed;
        int               got;
        int               base;
        logic             prev_ready;
        logic             fp_done;
        logic             saw_valid;
        job_t             e;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0; in_tag = '0; exp_jc = 16'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mm_start", 256'(mm_start), 256'(0));
        chk("rst_mm_rst", 256'(mm_rst), 256'(1));
        chk("rst_mm_xy", mm_x | mm_y, '0);
        chk("rst_out", {out_q[W-6:0], out_valid, out_err, out_tag}, '0);
        chk("rst_busy_ready", 256'({busy, in_ready}), 256'(2'b11));
        chk("rst_job_count", 256'(job_count), 256'(0));
        step(); step();
        #2 rst_n = 1'b1;
        step();
        chk("init_mm_rst", 256'(mm_rst), 256'(1));
        step();
        chk("init_to_idle", 256'({busy, mm_rst}), 256'(0));

        // Single job with the canonical operands.
        do_job(256'd3, 256'd5, 4'hA, 40);

        // Watchdog abort, then a normal job; done and timeout coincident; just past the limit.
        do_job(rand256(), rand256(), 4'h3, 0);
        do_job(rand256(), rand256(), 4'h4, 7);
        do_job(rand256(), rand256(), 4'h5, TIMEOUT);
        do_job(rand256(), rand256(), 4'h6, TIMEOUT + 1);

        for (int k = 0; k < 3; k++) begin
            do_job(rand256(), rand256(), 4'(k + 8), int'($urandom_range(2, 20)));
        end

        // FIFO full with results back-pressured.
        out_ready = 1'b0; stub_lat = 5; base = n_start; pushed = 0;
        for (int k = 0; k < 6; k++) begin
            xs[k] = rand256();
            ys[k] = rand256();
        end
        for (int c = 0; c < 40; c++) begin
            if (pushed < 6) begin
                in_valid = 1'b1; in_x = xs[pushed]; in_y = ys[pushed]; in_tag = 4'(pushed + 1);
                if (in_ready) begin
                    e.x = xs[pushed]; e.y = ys[pushed]; e.tag = 4'(pushed + 1);
                    sb.push_back(e);
                    pushed++;
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        chk("full_pushed", 256'(pushed), 256'(5));
        chk("full_in_ready", 256'(in_ready), 256'(0));
        chk("full_one_start", 256'(n_start - base), 256'(1));
        chk("full_first_result", 256'(out_valid), 256'(1));

        out_ready = 1'b1; got = 0; fp_done = 1'b0; prev_ready = in_ready;
        for (int c = 0; c < 800 && got < 6; c++) begin
            if (mm_start && !fp_done) begin
                fp_done = 1'b1;
                chk("pop_full_no_push", 256'(prev_ready), 256'(0));
                chk("ready_after_pop", 256'(in_ready), 256'(1));
            end
            if (pushed < 6) begin
                in_valid = 1'b1; in_x = xs[pushed]; in_y = ys[pushed]; in_tag = 4'(pushed + 1);
                if (in_ready) begin
                    e.x = xs[pushed]; e.y = ys[pushed]; e.tag = 4'(pushed + 1);
                    sb.push_back(e);
                    pushed++;
                end
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 256'(1), 256'(0));
                end else begin
                    e = sb.pop_front();
                    chk("drain_q", out_q, ref_mul(e.x, e.y));
                    chk("drain_tag", 256'(out_tag), 256'(e.tag));
                    chk("drain_err", 256'(out_err), 256'(0));
                    exp_jc = exp_jc + 16'd1;
                end
                got++;
            end
            prev_ready = in_ready;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("drain_count", 256'(got), 256'(6));
        wait_idle();
        chk("drain_job_count", 256'(job_count), 256'(exp_jc));

        // Asynchronous reset ten cycles into a job that never finishes.
        stub_lat = 0;
        in_x = rand256(); in_y = rand256(); in_tag = 4'h7; in_valid = 1'b1;
        step();
        in_tag = 4'h8;
        step();
        in_tag = 4'h9;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("pre_reset_busy", 256'({busy, mm_rst, out_valid}), 256'(3'b100));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mm_rst", 256'({mm_rst, mm_start, busy}), 256'(3'b101));
        chk("mid_rst_mm_x", mm_x, '0);
        chk("mid_rst_out", 256'({out_valid, out_err, out_tag}), 256'(0));
        chk("mid_rst_jc_ready", 256'({job_count, in_ready}), 256'(1));
        step();
        #2 rst_n = 1'b1;
        exp_jc = 16'd0;
        base = n_start; saw_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        chk("post_rst_no_issue", 256'(n_start - base), 256'(0));
        chk("post_rst_no_stale", 256'(saw_valid), 256'(0));
        chk("post_rst_idle", 256'({busy, in_ready}), 256'(2'b01));

        // job_count wrap after preloading the counter.
        force dut.r_job_count = 16'hFFFF;
        step(); step();
        release dut.r_job_count;
        step();
        chk("preload", 256'(job_count), 256'(16'hFFFF));
        exp_jc = 16'hFFFF;
        do_job(rand256(), rand256(), 4'hE, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
